// File: rtl/fft_pkg.sv
// Shared types and encodings for the FFT butterfly controller and datapath glue.
package fft_pkg;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LD_REB  = 4'd1,
    LD_IMB  = 4'd2,
    LD_REW  = 4'd3,
    LD_IMW  = 4'd4,
    MUL1    = 4'd5,
    MUL2    = 4'd6,
    LD_REA  = 4'd7,
    LD_IMA  = 4'd8,
    OUT_REX = 4'd9,
    OUT_IMX = 4'd10,
    OUT_REY = 4'd11,
    OUT_IMY = 4'd12
  } bf_state_t;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_RSUB = 2'b10;

  localparam logic MUX_MUL_RE   = 1'b0;
  localparam logic MUX_MUL_IM   = 1'b1;
  localparam logic MUX_ALU_PROD = 1'b0;
  localparam logic MUX_ALU_A    = 1'b1;
  localparam logic OUT_SEL_RE   = 1'b0;
  localparam logic OUT_SEL_IM   = 1'b1;

  // States where a press issues a one-cycle strobe before advancing.
  function automatic logic has_strobe(input bf_state_t s);
    return (s inside {LD_REB, LD_IMB, LD_REW, LD_IMW, MUL1, MUL2, LD_REA, LD_IMA});
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, down-counting debounce
// timer and a single-cycle pulse on each accepted rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic Clock,
  input  logic nReset,
  input  logic ReadyIn,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DEB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          deb_q;
  logic          deb_prev;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= ReadyIn;
      sync_2 <= sync_1;
    end
  end

  // Timer reloads whenever input agrees with the accepted level; the level
  // flips on the cycle the timer reaches terminal count while still differing.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else if (sync_2 == deb_q) begin
      cnt_q <= RELOAD;
    end else if (cnt_q == '0) begin
      deb_q <= sync_2;
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) deb_prev <= 1'b0;
    else         deb_prev <= deb_q;
  end

  assign level = deb_q;
  assign press = deb_q & ~deb_prev;

endmodule

// File: rtl/butterfly_ctrl.sv
// Sequencing controller for the radix-2 FFT butterfly datapath: walks operand
// loads, two multiply passes and four result displays, one button press per step.
module butterfly_ctrl
  import fft_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       ReadyIn,
  output logic       enReb,
  output logic       enImb,
  output logic       enRew,
  output logic       enImw,
  output logic       enRea,
  output logic       enIma,
  output logic       load,
  output logic       enout,
  output logic       mux_mul,
  output logic       mux_alu,
  output logic [1:0] sub1,
  output logic [1:0] sub2,
  output logic       out_sel,
  output logic       rst,
  output logic       hold,
  output logic [3:0] state_dbg,
  output logic       busy
);

  // state   | meaning
  // IDLE    | waiting; clears Imb, Rea, Ima in the datapath
  // LD_REB  | load Re B from switches
  // LD_IMB  | load Im B
  // LD_REW  | load Re W
  // LD_IMW  | load Im W
  // MUL1    | accumulate Reb*Rew, Reb*Imw
  // MUL2    | finish Re(BW), Im(BW)
  // LD_REA  | load Re A
  // LD_IMA  | load Im A
  // OUT_REX | show Re(A+BW)
  // OUT_IMX | show Im(A+BW)
  // OUT_REY | show Re(A-BW)
  // OUT_IMY | show Im(A-BW)

  bf_state_t state_q;
  bf_state_t state_d;
  bf_state_t state_succ;
  logic      strb_q;
  logic      strb_d;
  logic      press;
  logic      deb_level;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .Clock   (Clock),
    .nReset  (nReset),
    .ReadyIn (ReadyIn),
    .level   (deb_level),
    .press   (press)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      strb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_succ = IDLE;
    case (state_q)
      IDLE:    state_succ = LD_REB;
      LD_REB:  state_succ = LD_IMB;
      LD_IMB:  state_succ = LD_REW;
      LD_REW:  state_succ = LD_IMW;
      LD_IMW:  state_succ = MUL1;
      MUL1:    state_succ = MUL2;
      MUL2:    state_succ = LD_REA;
      LD_REA:  state_succ = LD_IMA;
      LD_IMA:  state_succ = OUT_REX;
      OUT_REX: state_succ = OUT_IMX;
      OUT_IMX: state_succ = OUT_REY;
      OUT_REY: state_succ = OUT_IMY;
      OUT_IMY: state_succ = IDLE;
      default: state_succ = IDLE;
    endcase
  end

  // A set strobe flag always wins, so a press landing on the strobe cycle is dropped.
  always_comb begin
    state_d = state_q;
    strb_d  = 1'b0;
    if (strb_q) begin
      state_d = state_succ;
    end else if (press) begin
      if (has_strobe(state_q)) strb_d  = 1'b1;
      else                     state_d = state_succ;
    end
  end

  always_comb begin
    enReb   = 1'b0;
    enImb   = 1'b0;
    enRew   = 1'b0;
    enImw   = 1'b0;
    enRea   = 1'b0;
    enIma   = 1'b0;
    load    = 1'b0;
    enout   = 1'b0;
    mux_mul = MUX_MUL_RE;
    mux_alu = MUX_ALU_PROD;
    sub1    = ALU_ADD;
    sub2    = ALU_ADD;
    out_sel = OUT_SEL_RE;
    rst     = 1'b0;
    hold    = 1'b0;
    case (state_q)
      IDLE: ;
      LD_REB: begin rst = 1'b1; enReb = strb_q; end
      LD_IMB: begin rst = 1'b1; enImb = strb_q; end
      LD_REW: begin rst = 1'b1; enRew = strb_q; end
      LD_IMW: begin rst = 1'b1; enImw = strb_q; end
      MUL1: begin
        rst  = 1'b1;
        load = strb_q;
      end
      MUL2: begin
        rst     = 1'b1;
        hold    = 1'b1;
        mux_mul = MUX_MUL_IM;
        sub1    = ALU_RSUB;
        load    = strb_q;
      end
      LD_REA: begin rst = 1'b1; hold = 1'b1; enRea = strb_q; end
      LD_IMA: begin rst = 1'b1; hold = 1'b1; enIma = strb_q; end
      OUT_REX, OUT_IMX, OUT_REY, OUT_IMY: begin
        rst     = 1'b1;
        hold    = 1'b1;
        mux_alu = MUX_ALU_A;
        enout   = 1'b1;
        out_sel = (state_q inside {OUT_IMX, OUT_IMY}) ? OUT_SEL_IM : OUT_SEL_RE;
        if (state_q inside {OUT_REY, OUT_IMY}) begin
          sub1 = ALU_SUB;
          sub2 = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  assign state_dbg = state_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_butterfly_ctrl.sv
// Directed bench for butterfly_ctrl with a small behavioural butterfly datapath.
module tb_butterfly_ctrl;

  localparam int DEB = 16;

  localparam logic [3:0] S_IDLE = 4'd0, S_LD_REB = 4'd1, S_LD_IMB = 4'd2,
    S_LD_REW = 4'd3, S_LD_IMW = 4'd4, S_MUL1 = 4'd5, S_MUL2 = 4'd6,
    S_LD_REA = 4'd7, S_LD_IMA = 4'd8, S_OUT_REX = 4'd9, S_OUT_IMX = 4'd10,
    S_OUT_REY = 4'd11, S_OUT_IMY = 4'd12;

  logic       Clock = 1'b0;
  logic       nReset;
  logic       ReadyIn;
  logic       enReb, enImb, enRew, enImw, enRea, enIma, load;
  logic       enout, mux_mul, mux_alu, out_sel, rst, hold, busy;
  logic [1:0] sub1, sub2;
  logic [3:0] state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  butterfly_ctrl #(.DEB_CYCLES(DEB)) dut (
    .Clock(Clock), .nReset(nReset), .ReadyIn(ReadyIn),
    .enReb(enReb), .enImb(enImb), .enRew(enRew), .enImw(enImw),
    .enRea(enRea), .enIma(enIma), .load(load), .enout(enout),
    .mux_mul(mux_mul), .mux_alu(mux_alu), .sub1(sub1), .sub2(sub2),
    .out_sel(out_sel), .rst(rst), .hold(hold), .state_dbg(state_dbg), .busy(busy)
  );

  always #5 Clock = ~Clock;

  logic [6:0] strb_vec;
  logic [9:0] ctl_vec;
  assign strb_vec = {load, enIma, enRea, enImw, enRew, enImb, enReb};
  assign ctl_vec  = {mux_mul, mux_alu, sub1, sub2, rst, hold, enout, out_sel};

  // Behavioural datapath (Q1.7) driven by the controller outputs.
  logic [7:0] sw = 8'h00;
  logic [7:0] reb = 8'h00, imb = 8'h00, rew = 8'h00, imw = 8'h00;
  logic [7:0] rea = 8'h00, ima = 8'h00, acc_re = 8'h00, acc_im = 8'h00;
  logic [7:0] alu_re, alu_im, leds;

  function automatic logic [7:0] q7mul(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [15:0] p;
    p = a * b;
    return p[14:7];
  endfunction

  function automatic logic [7:0] alu(input logic [1:0] m, input logic [7:0] a, input logic [7:0] b);
    case (m)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return b - a;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    alu_re = alu(sub1, mux_alu ? rea : (mux_mul ? q7mul(imb, imw) : q7mul(reb, rew)),
                 hold ? acc_re : 8'h00);
    alu_im = alu(sub2, mux_alu ? ima : (mux_mul ? q7mul(imb, rew) : q7mul(reb, imw)),
                 hold ? acc_im : 8'h00);
    leds   = enout ? (out_sel ? alu_im : alu_re) : 8'h00;
  end

  always @(posedge Clock) begin
    if (!rst) begin imb <= 8'h00; rea <= 8'h00; end
    if (!hold) ima <= 8'h00;
    if (enReb) reb <= sw;
    if (enImb) imb <= sw;
    if (enRew) rew <= sw;
    if (enImw) imw <= sw;
    if (enRea) rea <= sw;
    if (enIma) ima <= sw;
    if (load) begin acc_re <= alu_re; acc_im <= alu_im; end
  end

  // Strobe monitor: overlaps and strobes lasting more than one cycle.
  int         strobe_cycles = 0;
  int         overlap_cnt   = 0;
  int         long_cnt      = 0;
  logic [6:0] prev_vec      = 7'h0;
  always @(negedge Clock) begin
    if ($countones(strb_vec) > 1) overlap_cnt++;
    if (strb_vec != 7'h0) begin
      strobe_cycles++;
      if (prev_vec != 7'h0) long_cnt++;
    end
    prev_vec = strb_vec;
  end

  function automatic logic [9:0] exp_ctl(input logic [3:0] s);
    // {mux_mul, mux_alu, sub1, sub2, rst, hold, enout, out_sel}
    case (s)
      S_IDLE:                              return 10'b0_0_00_00_0_0_0_0;
      S_LD_REB, S_LD_IMB, S_LD_REW, S_LD_IMW: return 10'b0_0_00_00_1_0_0_0;
      S_MUL1:                              return 10'b0_0_00_00_1_0_0_0;
      S_MUL2:                              return 10'b1_0_10_00_1_1_0_0;
      S_LD_REA, S_LD_IMA:                  return 10'b0_0_00_00_1_1_0_0;
      S_OUT_REX:                           return 10'b0_1_00_00_1_1_1_0;
      S_OUT_IMX:                           return 10'b0_1_00_00_1_1_1_1;
      S_OUT_REY:                           return 10'b0_1_01_01_1_1_1_0;
      S_OUT_IMY:                           return 10'b0_1_01_01_1_1_1_1;
      default:                             return 10'h3FF;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One button press; sidx is the expected strobe bit or -1 for a plain advance.
  task automatic step(input int sidx, input logic [3:0] nxt);
    logic [3:0] cur;
    logic [9:0] cur_ctl;
    int         lat;
    cur     = state_dbg;
    cur_ctl = ctl_vec;
    ReadyIn = 1'b1;
    lat     = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (strb_vec == 7'h0 && state_dbg == cur && lat < 4 * DEB);
    check("press_latency", 16'(lat), 16'(DEB + 3));
    if (sidx >= 0) begin
      check("strobe_sel", 16'(strb_vec), 16'(7'h1 << sidx));
      check("state_in_strobe", 16'(state_dbg), 16'(cur));
      check("ctl_in_strobe", 16'(ctl_vec), 16'(cur_ctl));
      @(negedge Clock);
      check("strobe_clear", 16'(strb_vec), 16'h0);
    end else begin
      check("no_strobe", 16'(strb_vec), 16'h0);
    end
    check("next_state", 16'(state_dbg), 16'(nxt));
    check("moore_ctl", 16'(ctl_vec), 16'(exp_ctl(nxt)));
    check("busy", 16'(busy), 16'(nxt != S_IDLE));
    ReadyIn = 1'b0;
    repeat (2 * DEB + 8) @(negedge Clock);
    check("state_after_release", 16'(state_dbg), 16'(nxt));
  endtask

  // Starts in LD_REB and returns to IDLE.
  task automatic butterfly(input logic [7:0] b_re, input logic [7:0] b_im,
                           input logic [7:0] w_re, input logic [7:0] w_im,
                           input logic [7:0] a_re, input logic [7:0] a_im,
                           input logic [7:0] x_re, input logic [7:0] x_im,
                           input logic [7:0] y_re, input logic [7:0] y_im);
    sw = b_re; step(0, S_LD_IMB);
    sw = b_im; step(1, S_LD_REW);
    sw = w_re; step(2, S_LD_IMW);
    sw = w_im; step(3, S_MUL1);
    step(6, S_MUL2);
    step(6, S_LD_REA);
    sw = a_re; step(4, S_LD_IMA);
    sw = a_im; step(5, S_OUT_REX);
    check("led_re_x", 16'(leds), 16'(x_re));
    step(-1, S_OUT_IMX);
    check("led_im_x", 16'(leds), 16'(x_im));
    step(-1, S_OUT_REY);
    check("led_re_y", 16'(leds), 16'(y_re));
    step(-1, S_OUT_IMY);
    check("led_im_y", 16'(leds), 16'(y_im));
    step(-1, S_IDLE);
    check("led_idle", 16'(leds), 16'h0);
  endtask

  initial begin
    int lat;
    nReset  = 1'b0;
    ReadyIn = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_state", 16'(state_dbg), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_strobes", 16'(strb_vec), 16'h0);
    check("rst_ctl", 16'(ctl_vec), 16'h0);

    nReset = 1'b1;
    repeat (100) @(negedge Clock);
    check("idle_no_strobe", 16'(strobe_cycles), 16'h0);
    check("idle_state", 16'(state_dbg), 16'h0);

    // Glitch one cycle short of the debounce window.
    ReadyIn = 1'b1;
    repeat (DEB - 1) @(negedge Clock);
    ReadyIn = 1'b0;
    repeat (3 * DEB) @(negedge Clock);
    check("glitch_state", 16'(state_dbg), 16'h0);
    check("glitch_busy", 16'(busy), 16'h0);

    // Long hold: exactly one press, IDLE -> LD_REB.
    ReadyIn = 1'b1;
    lat = 0;
    do begin
      @(negedge Clock);
      lat++;
    end while (state_dbg == S_IDLE && lat < 10 * DEB);
    check("hold_latency", 16'(lat), 16'(DEB + 3));
    repeat (5 * DEB - lat) @(negedge Clock);
    check("hold_state", 16'(state_dbg), 16'(S_LD_REB));
    check("hold_no_strobe", 16'(strobe_cycles), 16'h0);
    ReadyIn = 1'b0;
    repeat (2 * DEB + 8) @(negedge Clock);
    check("hold_ctl", 16'(ctl_vec), 16'(exp_ctl(S_LD_REB)));

    butterfly(8'h40, 8'h00, 8'h40, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00);

    step(-1, S_LD_REB);
    butterfly(8'h00, 8'h40, 8'h00, 8'h40, 8'h00, 8'h00, 8'hE0, 8'h00, 8'h20, 8'h00);

    // Reset in MUL2, then a clean sequence.
    step(-1, S_LD_REB);
    sw = 8'h11; step(0, S_LD_IMB);
    sw = 8'h22; step(1, S_LD_REW);
    sw = 8'h33; step(2, S_LD_IMW);
    sw = 8'h44; step(3, S_MUL1);
    step(6, S_MUL2);
    #2 nReset = 1'b0;
    #1;
    check("midrst_state", 16'(state_dbg), 16'h0);
    check("midrst_ctl", 16'(ctl_vec), 16'h0);
    check("midrst_strobes", 16'(strb_vec), 16'h0);
    check("midrst_busy", 16'(busy), 16'h0);
    @(negedge Clock);
    nReset = 1'b1;
    repeat (4) @(negedge Clock);
    step(-1, S_LD_REB);
    butterfly(8'h40, 8'h00, 8'h40, 8'h00, 8'h20, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00);

    check("strobe_overlap", 16'(overlap_cnt), 16'h0);
    check("strobe_width", 16'(long_cnt), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
